// File: rtl/register_file_mp_pkg.sv
// register_file_mp_pkg: shared register-index types and zero-register helper
package register_file_mp_pkg;

    localparam int RF_DEPTH = 32;
    localparam int ZERO_IDX = 0;

    typedef logic [$clog2(RF_DEPTH)-1:0] regidx_t;

    // True when idx is the hard-wired zero register of a file built with zero_reg set
    function automatic logic zero_slot(input int idx, input int zero_reg);
        return zero_reg != 0 && idx == ZERO_IDX;
    endfunction

endpackage

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: per-index winning write port and same-index conflict detect
module rf_write_arbiter
    import register_file_mp_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int NWRITE = 2,
    parameter int ZERO_REG = 1,
    localparam int AW = $clog2(DEPTH),
    localparam int PW = NWRITE > 1 ? $clog2(NWRITE) : 1
) (
    input  logic [NWRITE-1:0]              wen,
    input  logic [NWRITE-1:0][AW-1:0]      wsel,
    output logic [DEPTH-1:0]               hit,
    output logic [DEPTH-1:0][PW-1:0]       win,
    output logic                           conflict
);

    // Scan ports in ascending order so the highest-numbered enabled port is left as winner
    always_comb begin
        hit = '0;
        win = '0;
        conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int p = 0; p < NWRITE; p++) begin
                if (wen[p] && wsel[p] == AW'(i) && !zero_slot(i, ZERO_REG)) begin
                    conflict = conflict | hit[i];
                    hit[i] = 1'b1;
                    win[i] = PW'(p);
                end
            end
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with bypass, zero register and pending scoreboard
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NREAD = 2,
    parameter int NWRITE = 2,
    parameter int BYPASS = 1,
    parameter int ZERO_REG = 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic [NWRITE-1:0]               wen,
    input  logic [NWRITE-1:0][AW-1:0]       wsel,
    input  logic [NWRITE-1:0][WIDTH-1:0]    wdat,
    input  logic [NREAD-1:0][AW-1:0]        rsel,
    output logic [NREAD-1:0][WIDTH-1:0]     rdat,
    output logic [NREAD-1:0]                rpend,
    input  logic                            claim_en,
    input  logic [AW-1:0]                   claim_sel,
    output logic [DEPTH-1:0]                pending,
    output logic                            wconflict
);

    localparam int PW = NWRITE > 1 ? $clog2(NWRITE) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            hit;
    logic [DEPTH-1:0][PW-1:0]    win;
    logic                        conflict;

    rf_write_arbiter #(
        .DEPTH(DEPTH),
        .NWRITE(NWRITE),
        .ZERO_REG(ZERO_REG)
    ) u_arb (
        .wen(wen),
        .wsel(wsel),
        .hit(hit),
        .win(win),
        .conflict(conflict)
    );

    // Storage, scoreboard and conflict flag; a claim outranks a write to the same index
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            regs <= '0;
            pending <= '0;
            wconflict <= 1'b0;
        end else begin
            wconflict <= conflict;
            for (int i = 0; i < DEPTH; i++) begin
                if (hit[i]) regs[i] <= wdat[win[i]];
                pending[i] <= (claim_en && claim_sel == AW'(i) && !zero_slot(i, ZERO_REG)) | (pending[i] & ~hit[i]);
            end
        end
    end

    // Read ports: zero register first, then same-cycle bypass, then stored state
    always_comb begin
        rdat = '0;
        rpend = '0;
        for (int k = 0; k < NREAD; k++) begin
            rdat[k] = zero_slot(int'(rsel[k]), ZERO_REG) ? '0 :
                      (BYPASS != 0 && hit[rsel[k]]) ? wdat[win[rsel[k]]] : regs[rsel[k]];
            rpend[k] = pending[rsel[k]] & ~(BYPASS != 0 && hit[rsel[k]]);
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: table, directed and random checks of both bypass variants against a model
module tb_register_file_mp;
    import register_file_mp_pkg::*;

    logic                 CLK = 1'b0;
    logic                 nRST = 1'b0;
    logic [1:0]           wen;
    logic [1:0][4:0]      wsel;
    logic [1:0][31:0]     wdat;
    logic [1:0][4:0]      rsel;
    logic                 claim_en;
    regidx_t              claim_sel;
    logic [1:0][31:0]     rdat_b, rdat_n;
    logic [1:0]           rpend_b, rpend_n;
    logic [31:0]          pend_b, pend_n;
    logic                 wc_b, wc_n;

    register_file_mp #(.BYPASS(1)) u_byp (
        .CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .wdat(wdat), .rsel(rsel),
        .rdat(rdat_b), .rpend(rpend_b), .claim_en(claim_en), .claim_sel(claim_sel),
        .pending(pend_b), .wconflict(wc_b)
    );

    register_file_mp #(.BYPASS(0)) u_nob (
        .CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .wdat(wdat), .rsel(rsel),
        .rdat(rdat_n), .rpend(rpend_n), .claim_en(claim_en), .claim_sel(claim_sel),
        .pending(pend_n), .wconflict(wc_n)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total = 0;

    logic [31:0] mreg [32];
    bit          mpend [32];
    bit          mconf;

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  ws0, ws1;
        logic [31:0] wd0, wd1;
        logic [4:0]  rs;
        logic        ce;
        logic [4:0]  cs;
        logic [31:0] rb, rn;
        logic        rp, rpn, pd, wc;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            mreg[i] = '0;
            mpend[i] = 1'b0;
        end
        mconf = 1'b0;
    endfunction

    function automatic bit written(input int idx);
        for (int p = 0; p < 2; p++) if (wen[p] && int'(wsel[p]) == idx) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_rdat(input int k, input bit byp);
        int idx = int'(rsel[k]);
        logic [31:0] v;
        if (idx == 0) return '0;
        v = mreg[idx];
        if (byp) for (int p = 0; p < 2; p++) if (wen[p] && int'(wsel[p]) == idx) v = wdat[p];
        return v;
    endfunction

    function automatic bit exp_rpend(input int k, input bit byp);
        int idx = int'(rsel[k]);
        return mpend[idx] && !(byp && written(idx));
    endfunction

    function automatic logic [31:0] mpend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = mpend[i];
        return v;
    endfunction

    function automatic void model_update();
        int cnt [32];
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        for (int p = 0; p < 2; p++) begin
            if (wen[p] && wsel[p] != 0) begin
                cnt[wsel[p]]++;
                mreg[wsel[p]] = wdat[p];
                mpend[wsel[p]] = 1'b0;
            end
        end
        mconf = 1'b0;
        for (int i = 0; i < 32; i++) if (cnt[i] >= 2) mconf = 1'b1;
        if (claim_en && claim_sel != 0) mpend[claim_sel] = 1'b1;
    endfunction

    task automatic idle();
        wen = '0;
        wsel = '0;
        wdat = '0;
        claim_en = 1'b0;
        claim_sel = '0;
    endtask

    task automatic settle_check();
        #4;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rdat_byp[%0d]", k), rdat_b[k], exp_rdat(k, 1'b1));
            chk($sformatf("rdat_nob[%0d]", k), rdat_n[k], exp_rdat(k, 1'b0));
            chk($sformatf("rpend_byp[%0d]", k), rpend_b[k], exp_rpend(k, 1'b1));
            chk($sformatf("rpend_nob[%0d]", k), rpend_n[k], exp_rpend(k, 1'b0));
        end
        chk("pending_byp", pend_b, mpend_vec());
        chk("pending_nob", pend_n, mpend_vec());
        chk("wconflict_byp", wc_b, mconf);
        chk("wconflict_nob", wc_n, mconf);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    initial begin
        tbl[0]  = '{2'b11, 5'd3, 5'd3, 32'hDEADBEEF, 32'h12345678, 5'd3, 1'b0, 5'd0, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 1'b0, 5'd0, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 1'b0, 5'd0, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{2'b01, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0, 5'd7, 1'b0, 5'd0, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 1'b0, 5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 1'b1, 5'd9, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 5'd9, 1'b0, 5'd0, 32'h99, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 1'b0, 5'd0, 32'h99, 32'h99, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{2'b10, 5'd0, 5'd9, 32'h0, 32'h55, 5'd9, 1'b1, 5'd9, 32'h55, 32'h99, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 1'b0, 5'd0, 32'h55, 32'h55, 1'b1, 1'b1, 1'b1, 1'b0};

        model_reset();
        idle();
        rsel = '0;
        #12;
        chk("reset_pending", pend_b, 32'h0);
        chk("reset_wconflict", wc_b, 1'b0);
        chk("reset_rdat", rdat_n[0], 32'h0);
        nRST = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            wen = tbl[i].wen;
            wsel[0] = tbl[i].ws0;
            wsel[1] = tbl[i].ws1;
            wdat[0] = tbl[i].wd0;
            wdat[1] = tbl[i].wd1;
            rsel[0] = tbl[i].rs;
            rsel[1] = 5'd31 - tbl[i].rs;
            claim_en = tbl[i].ce;
            claim_sel = tbl[i].cs;
            settle_check();
            chk($sformatf("tbl%0d_rdat_byp", i), rdat_b[0], tbl[i].rb);
            chk($sformatf("tbl%0d_rdat_nob", i), rdat_n[0], tbl[i].rn);
            chk($sformatf("tbl%0d_rpend_byp", i), rpend_b[0], tbl[i].rp);
            chk($sformatf("tbl%0d_rpend_nob", i), rpend_n[0], tbl[i].rpn);
            chk($sformatf("tbl%0d_pending", i), pend_b[tbl[i].rs], tbl[i].pd);
            chk($sformatf("tbl%0d_wconflict", i), wc_b, tbl[i].wc);
            tick();
        end

        wen = 2'b11;
        wsel[0] = 5'd5;
        wsel[1] = 5'd5;
        wdat[0] = 32'h11111111;
        wdat[1] = 32'h55555555;
        claim_en = 1'b1;
        claim_sel = 5'd5;
        rsel[0] = 5'd5;
        settle_check();
        tick();
        idle();
        #1;
        chk("pre_reset_reg5", rdat_n[0], 32'h55555555);
        chk("pre_reset_wconflict", wc_b, 1'b1);
        chk("pre_reset_pending5", pend_b[5], 1'b1);
        nRST = 1'b0;
        #1;
        chk("reset_reg5_byp", rdat_b[0], 32'h0);
        chk("reset_reg5_nob", rdat_n[0], 32'h0);
        chk("reset_pending_all", pend_b, 32'h0);
        chk("reset_wconflict_all", wc_b, 1'b0);
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        settle_check();
        tick();

        wen = 2'b01;
        wsel[0] = 5'd4;
        wdat[0] = 32'h44444444;
        claim_en = 1'b1;
        claim_sel = 5'd4;
        rsel[0] = 5'd4;
        #3;
        nRST = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        idle();
        #1;
        chk("midreset_reg4_byp", rdat_b[0], 32'h0);
        chk("midreset_reg4_nob", rdat_n[0], 32'h0);
        chk("midreset_pending", pend_b, 32'h0);
        settle_check();
        tick();

        for (int n = 0; n < 400; n++) begin
            wen = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                wsel[p] = 5'($urandom_range(0, 7));
                wdat[p] = $urandom;
                rsel[p] = 5'($urandom_range(0, 7));
            end
            claim_en = ($urandom % 3) == 0;
            claim_sel = regidx_t'($urandom_range(0, 7));
            settle_check();
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
